// File: rtl/zx_keymatrix.sv
// ZX Spectrum 8x5 keyboard matrix fed by PS/2 set-2 scan codes, answering ULA port-0xFE row reads.
// Optional macro ZX_COMBO_KEYS_EN adds CAPS-shift combo keys (backspace, cursor arrows).
module zx_keymatrix #(
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  input  logic       scan_code_error,
  input  logic [7:0] row_sel,
  output logic [4:0] key_col,
  output logic       any_key
);

  localparam int CNT_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_SKIP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [39:0]       matrix, set_mask, clr_mask, eff, combo_eff;

  // Bit index is row*5 + column.
  function automatic logic [39:0] std_mask(input logic [7:0] code);
    logic [39:0] m;
    m = '0;
    case (code)
      8'h12, 8'h59: m[0] = 1'b1;
      8'h1A: m[1]  = 1'b1;
      8'h22: m[2]  = 1'b1;
      8'h21: m[3]  = 1'b1;
      8'h2A: m[4]  = 1'b1;
      8'h1C: m[5]  = 1'b1;
      8'h1B: m[6]  = 1'b1;
      8'h23: m[7]  = 1'b1;
      8'h2B: m[8]  = 1'b1;
      8'h34: m[9]  = 1'b1;
      8'h15: m[10] = 1'b1;
      8'h1D: m[11] = 1'b1;
      8'h24: m[12] = 1'b1;
      8'h2D: m[13] = 1'b1;
      8'h2C: m[14] = 1'b1;
      8'h16: m[15] = 1'b1;
      8'h1E: m[16] = 1'b1;
      8'h26: m[17] = 1'b1;
      8'h25: m[18] = 1'b1;
      8'h2E: m[19] = 1'b1;
      8'h45: m[20] = 1'b1;
      8'h46: m[21] = 1'b1;
      8'h3E: m[22] = 1'b1;
      8'h3D: m[23] = 1'b1;
      8'h36: m[24] = 1'b1;
      8'h4D: m[25] = 1'b1;
      8'h44: m[26] = 1'b1;
      8'h43: m[27] = 1'b1;
      8'h3C: m[28] = 1'b1;
      8'h35: m[29] = 1'b1;
      8'h5A: m[30] = 1'b1;
      8'h4B: m[31] = 1'b1;
      8'h42: m[32] = 1'b1;
      8'h3B: m[33] = 1'b1;
      8'h33: m[34] = 1'b1;
      8'h29: m[35] = 1'b1;
      8'h14: m[36] = 1'b1;
      8'h3A: m[37] = 1'b1;
      8'h31: m[38] = 1'b1;
      8'h32: m[39] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Only right ctrl has a physical mapping among E0-prefixed codes.
  function automatic logic [39:0] ext_mask(input logic [7:0] code);
    logic [39:0] m;
    m = '0;
    if (code == 8'h14) m[36] = 1'b1;
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      matrix <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      matrix <= (matrix & ~clr_mask) | set_mask;
    end
  end

  // Error strobe overrides a simultaneous ready and drops the byte.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_mask  = '0;
    clr_mask  = '0;
    if (scan_code_error) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (scan_code_ready) begin
      case (state)
        S_IDLE: begin
          if (scan_code == 8'hE0) begin
            state_nxt = S_EXT;
          end else if (scan_code == 8'hF0) begin
            state_nxt = S_BRK;
          end else if (scan_code == 8'hE1) begin
            state_nxt = S_SKIP;
            cnt_nxt   = CNT_W'(PAUSE_SKIP);
          end else begin
            set_mask = std_mask(scan_code);
          end
        end
        S_EXT: begin
          if (scan_code == 8'hF0) begin
            state_nxt = S_EXTBRK;
          end else begin
            set_mask  = ext_mask(scan_code);
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          clr_mask  = std_mask(scan_code);
          state_nxt = S_IDLE;
        end
        S_EXTBRK: begin
          clr_mask  = ext_mask(scan_code);
          state_nxt = S_IDLE;
        end
        S_SKIP: begin
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef ZX_COMBO_KEYS_EN
  logic [4:0] combo, combo_set, combo_clr;

  function automatic logic [4:0] std_combo(input logic [7:0] code);
    return (code == 8'h66) ? 5'b00001 : 5'b00000;
  endfunction

  function automatic logic [4:0] ext_combo(input logic [7:0] code);
    logic [4:0] f;
    f = '0;
    case (code)
      8'h6B:   f[1] = 1'b1;
      8'h72:   f[2] = 1'b1;
      8'h75:   f[3] = 1'b1;
      8'h74:   f[4] = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  always_comb begin
    combo_set = '0;
    combo_clr = '0;
    if (!scan_code_error && scan_code_ready) begin
      case (state)
        S_IDLE:   combo_set = std_combo(scan_code);
        S_EXT:    combo_set = ext_combo(scan_code);
        S_BRK:    combo_clr = std_combo(scan_code);
        S_EXTBRK: combo_clr = ext_combo(scan_code);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) combo <= '0;
    else        combo <= (combo & ~combo_clr) | combo_set;
  end

  // Combos only add to the effective matrix, so a physically held CAPS or digit survives release.
  always_comb begin
    combo_eff = '0;
    if (combo[0]) begin combo_eff[0] = 1'b1; combo_eff[20] = 1'b1; end
    if (combo[1]) begin combo_eff[0] = 1'b1; combo_eff[19] = 1'b1; end
    if (combo[2]) begin combo_eff[0] = 1'b1; combo_eff[24] = 1'b1; end
    if (combo[3]) begin combo_eff[0] = 1'b1; combo_eff[23] = 1'b1; end
    if (combo[4]) begin combo_eff[0] = 1'b1; combo_eff[22] = 1'b1; end
  end
`else
  assign combo_eff = '0;
`endif

  assign eff     = matrix | combo_eff;
  assign any_key = |eff;

  always_comb begin
    key_col = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!row_sel[r] && eff[r*5+c]) key_col[c] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zx_keymatrix.sv
// Scoreboard bench for zx_keymatrix: stimulus queues expected port reads, a negedge monitor checks them.
module tb_zx_keymatrix;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_code_ready = 1'b0;
  logic       scan_code_error = 1'b0;
  logic [7:0] row_sel = 8'hFF;
  logic [4:0] key_col;
  logic       any_key;

  zx_keymatrix #(.PAUSE_SKIP(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .scan_code_error (scan_code_error),
    .row_sel         (row_sel),
    .key_col         (key_col),
    .any_key         (any_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] kc;
    logic       ak;
    string      name;
  } exp_t;

  exp_t sb[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (chk_req) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: got key_col=%b any_key=%b, required a queued expectation", key_col, any_key);
      end else begin
        e = sb.pop_front();
        if (key_col !== e.kc || any_key !== e.ak) begin
          failures++;
          $display("FAIL %s: key_col=%b any_key=%b, required key_col=%b any_key=%b",
                   e.name, key_col, any_key, e.kc, e.ak);
        end
      end
    end
  end

  task automatic send(input logic [7:0] code, input logic rdy = 1'b1, input logic err = 1'b0);
    @(posedge clk); #1;
    scan_code       = code;
    scan_code_ready = rdy;
    scan_code_error = err;
    @(posedge clk); #1;
    scan_code_ready = 1'b0;
    scan_code_error = 1'b0;
  endtask

  task automatic chk(input logic [7:0] rs, input logic [4:0] kc, input logic ak, input string name);
    exp_t e;
    row_sel = rs;
    e.kc = kc;
    e.ak = ak;
    e.name = name;
    sb.push_back(e);
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_sel = 8'hFE;
    repeat (3) @(posedge clk);
    #1;
    chk(8'hFE, 5'b11111, 1'b0, "in_reset");
    reset = 1'b1;
    chk(8'hFE, 5'b11111, 1'b0, "after_reset");

    send(8'h1A);
    chk(8'hFE, 5'b11101, 1'b1, "make_Z");
    send(8'hF0); send(8'h1A);
    chk(8'hFE, 5'b11111, 1'b0, "break_Z");

    send(8'h29); send(8'h16);
    chk(8'h7F, 5'b11110, 1'b1, "space_row7");
    chk(8'hF7, 5'b11110, 1'b1, "one_row3");
    chk(8'h77, 5'b11110, 1'b1, "rows_3_7");
    chk(8'hFF, 5'b11111, 1'b1, "no_row_sel");
    send(8'hF0); send(8'h29); send(8'hF0); send(8'h16);
    chk(8'h00, 5'b11111, 1'b0, "released_all");

    send(8'hE0); send(8'h14);
    chk(8'h7F, 5'b11101, 1'b1, "rctrl_sym");
    send(8'hE0); send(8'hF0); send(8'h14);
    chk(8'h7F, 5'b11111, 1'b0, "rctrl_release");
    send(8'h14);
    chk(8'h7F, 5'b11101, 1'b1, "lctrl_sym");
    send(8'hE0); send(8'hF0); send(8'h14);
    chk(8'h7F, 5'b11111, 1'b0, "ext_break_clears_sym");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk(8'h00, 5'b11111, 1'b0, "pause_skipped");
    send(8'h15);
    chk(8'hFB, 5'b11110, 1'b1, "after_pause_Q");
    send(8'hF0); send(8'h15);

    send(8'hF0); send(8'h1C, 1'b1, 1'b1); send(8'h1C);
    chk(8'hFD, 5'b11110, 1'b1, "error_resets_brk");
    chk(8'hFE, 5'b11111, 1'b1, "error_other_row");
    send(8'hF0); send(8'h1C);

    send(8'hE1); send(8'h00, 1'b0, 1'b1); send(8'h2A);
    chk(8'hFE, 5'b01111, 1'b1, "error_ends_skip");
    send(8'h2A);
    chk(8'hFE, 5'b01111, 1'b1, "typematic");
    send(8'hF0); send(8'h2A); send(8'hF0); send(8'h2A);
    chk(8'hFE, 5'b11111, 1'b0, "double_break");

    send(8'h12); send(8'h1D); send(8'h3E); send(8'h3C); send(8'h32);
    chk(8'h00, 5'b00000, 1'b1, "all_rows");
    chk(8'hAA, 5'b11000, 1'b1, "even_rows");
    chk(8'h55, 5'b00111, 1'b1, "odd_rows");
    send(8'hF0); send(8'h12); send(8'hF0); send(8'h1D); send(8'hF0); send(8'h3E);
    send(8'hF0); send(8'h3C); send(8'hF0); send(8'h32);
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'h1A);
    chk(8'h00, 5'b11111, 1'b0, "ignored_codes");

`ifdef ZX_COMBO_KEYS_EN
    send(8'h12); send(8'h66);
    chk(8'hFE, 5'b11110, 1'b1, "combo_bksp_caps");
    chk(8'hEF, 5'b11110, 1'b1, "combo_bksp_zero");
    send(8'hF0); send(8'h66);
    chk(8'hFE, 5'b11110, 1'b1, "combo_caps_held");
    chk(8'hEF, 5'b11111, 1'b1, "combo_zero_clear");
    send(8'hF0); send(8'h12);
    chk(8'h00, 5'b11111, 1'b0, "combo_all_clear");
    send(8'hE0); send(8'h75);
    chk(8'hEF, 5'b10111, 1'b1, "combo_up_seven");
    chk(8'hFE, 5'b11110, 1'b1, "combo_up_caps");
    send(8'hE0); send(8'hF0); send(8'h75);
    chk(8'h00, 5'b11111, 1'b0, "combo_up_release");
`else
    send(8'h66);
    chk(8'h00, 5'b11111, 1'b0, "bksp_ignored");
    send(8'hE0); send(8'h75);
    chk(8'h00, 5'b11111, 1'b0, "up_ignored");
    send(8'hE0); send(8'hF0); send(8'h75);
`endif

    send(8'h12);
    chk(8'hFE, 5'b11110, 1'b1, "caps_before_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    chk(8'hFE, 5'b11111, 1'b0, "async_reset_clears");
    reset = 1'b1;
    send(8'h5A);
    chk(8'hBF, 5'b11110, 1'b1, "enter_after_reset");

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
